// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   // One instruction-queue entry: the fetched word and the address it came from.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } instr_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory channel plus decoder handshake.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap freely.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty,
   output logic                       o_full
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-order queue, redirect flush.
// Optional same-cycle response bypass to the decoder: define FETCH_BYPASS_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  fif,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e  r_state;
   fetch_state_e  w_state_nxt;
   logic [31:0]   r_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] w_out_nxt;
   logic [CW-1:0] w_discard_nxt;
   logic          w_req_valid;
   logic          w_req_fire;
   logic          w_resp_fire;
   logic          w_resp_keep;
   logic          w_iq_push;
   logic          w_iq_empty;
   logic          w_iq_full;
   logic [CW-1:0] w_iq_count;
   logic          w_tq_empty;
   logic          w_tq_full;
   logic [CW-1:0] w_tq_count;
   logic [31:0]   w_tag_head;
   instr_entry_t  w_iq_in;
   instr_entry_t  w_iq_head;

   // Responses with nothing outstanding are ignored; redirect-cycle and FLUSH responses are stale.
   assign w_resp_fire = fif.imem_resp_valid && (r_outstanding != '0);
   assign w_resp_keep = w_resp_fire && (r_state == RUN) && !redirect;
   assign w_req_fire  = w_req_valid && fif.imem_req_ready;
   assign w_out_nxt   = r_outstanding + CW'(w_req_fire) - CW'(w_resp_fire);

   always_comb begin
      w_discard_nxt = r_discard;
      if (redirect)
         w_discard_nxt = w_out_nxt;
      else if ((r_state == FLUSH) && w_resp_fire)
         w_discard_nxt = r_discard - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BOOT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BOOT:    w_state_nxt = RUN;
         RUN:     if (redirect && (w_out_nxt != '0)) w_state_nxt = FLUSH;
         FLUSH:   if (!redirect && (w_discard_nxt == '0)) w_state_nxt = RUN;
         default: w_state_nxt = BOOT;
      endcase
   end

   // Credit: never have more words in flight or queued than the queue can hold.
   always_comb begin
      w_req_valid = 1'b0;
      if (r_state == RUN)
         w_req_valid = ((CW+1)'(r_outstanding) + (CW+1)'(w_iq_count)) < (CW+1)'(DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         if (redirect)        r_pc <= align_pc(redirect_pc);
         else if (w_req_fire) r_pc <= r_pc + 32'(INSTR_BYTES);
         r_outstanding <= w_out_nxt;
         r_discard     <= w_discard_nxt;
      end
   end

   assign fif.imem_req_valid = w_req_valid;
   assign fif.imem_req_addr  = r_pc;
   assign w_iq_in            = '{instr: fif.imem_resp_data, pc: w_tag_head};

`ifdef FETCH_BYPASS_EN
   logic w_bypass;
   assign w_bypass        = w_iq_empty && w_resp_keep;
   assign w_iq_push       = w_resp_keep && !(w_bypass && fif.instr_ready);
   assign fif.instr_valid = !w_iq_empty || w_bypass;
   assign fif.instr       = w_bypass ? fif.imem_resp_data : w_iq_head.instr;
   assign fif.instr_pc    = w_bypass ? w_tag_head : w_iq_head.pc;
`else
   assign w_iq_push       = w_resp_keep;
   assign fif.instr_valid = !w_iq_empty;
   assign fif.instr       = w_iq_head.instr;
   assign fif.instr_pc    = w_iq_head.pc;
`endif

   fetch_fifo #(.WIDTH($bits(instr_entry_t)), .DEPTH(DEPTH)) u_instr_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect),
      .i_push  (w_iq_push),
      .i_pop   (fif.instr_valid && fif.instr_ready),
      .i_data  (w_iq_in),
      .o_data  (w_iq_head),
      .o_count (w_iq_count),
      .o_empty (w_iq_empty),
      .o_full  (w_iq_full)
   );

   fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect),
      .i_push  (w_req_fire),
      .i_pop   (w_resp_keep),
      .i_data  (r_pc),
      .o_data  (w_tag_head),
      .o_count (w_tq_count),
      .o_empty (w_tq_empty),
      .o_full  (w_tq_full)
   );

   // Simulation-only sanity checks on memory protocol and queue bookkeeping.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(fif.imem_resp_valid && (r_outstanding == '0)))
            else $error("fetch_unit: imem response with nothing outstanding");
         assert (!(w_iq_push && w_iq_full)) else $error("fetch_unit: instruction queue overflow");
         assert (!(w_req_fire && w_tq_full)) else $error("fetch_unit: tag queue overflow");
         assert (!(w_resp_keep && w_tq_empty)) else $error("fetch_unit: response without tag");
         assert ((r_state != RUN) || (w_tq_count == r_outstanding))
            else $error("fetch_unit: tag count out of step with outstanding");
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, directed scenarios, then random traffic.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int unsigned DEPTH  = 2;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   fetch_unit_if fif ();

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fif         (fif.master),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } dword_t;

   mreq_t       mem_q[$];
   dword_t      dq[$];
   logic [31:0] req_log[$];
   logic [31:0] pc_log[$];
   logic [31:0] exp_pc;
   int          cyc;
   int          lat;
   bit          boot;
   bit          did_redir;
   int          n_cmp;
   int          n_bad;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic int stale_cnt();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].stale) n++;
      return n;
   endfunction

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
         else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req_valid"}, 32'(fif.imem_req_valid), 32'd0);
      chk({tag, "_req_addr"}, fif.imem_req_addr, RST_PC);
      chk({tag, "_instr_valid"}, 32'(fif.instr_valid), 32'd0);
      chk({tag, "_instr"}, fif.instr, 32'd0);
      chk({tag, "_instr_pc"}, fif.instr_pc, 32'd0);
   endtask

   // One clock: drive at negedge, sample, predict, then advance the reference model.
   // mode 0: no redirect, 1: redirect, 2: redirect only if a response and a request both fire.
   task automatic step(input bit rdy, input bit irdy, input int mode, input logic [31:0] rpc);
      bit     resp_now, rf, redir, keep;
      mreq_t  h;
      dword_t d;
      redirect = 1'b0;
      resp_now = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      fif.imem_resp_valid = resp_now;
      fif.imem_resp_data  = resp_now ? mem_word(mem_q[0].addr) : NOP_INSTR;
      fif.imem_req_ready  = rdy;
      fif.instr_ready     = irdy;
      #1;
      rf    = fif.imem_req_valid && rdy;
      redir = (mode == 1) || ((mode == 2) && resp_now && rf);
      redirect    = redir;
      redirect_pc = rpc;
      #1;
      keep = resp_now && !mem_q[0].stale && !redir;
      chk("req_valid", 32'(fif.imem_req_valid),
          32'(!boot && (stale_cnt() == 0) && (mem_q.size() + dq.size() < DEPTH)));
      chk("instr_valid", 32'(fif.instr_valid), 32'((dq.size() > 0) || (BYP && keep)));
      if (rf) chk("req_addr", fif.imem_req_addr, exp_pc);
      if (resp_now) begin
         h = mem_q.pop_front();
         if (keep) begin
            d.data = mem_word(h.addr);
            d.pc   = h.addr;
            dq.push_back(d);
         end
      end
      if (fif.instr_valid && irdy && (dq.size() > 0)) begin
         d = dq.pop_front();
         chk("instr", fif.instr, d.data);
         chk("instr_pc", fif.instr_pc, d.pc);
         pc_log.push_back(fif.instr_pc);
      end
      if (rf) begin
         h.addr  = fif.imem_req_addr;
         h.due   = cyc + lat;
         h.stale = redir;
         mem_q.push_back(h);
         req_log.push_back(fif.imem_req_addr);
      end
      if (redir) begin
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         dq.delete();
         exp_pc = {rpc[31:2], 2'b00};
      end else if (rf) begin
         exp_pc = exp_pc + 32'd4;
      end
      did_redir = redir;
      boot = 1'b0;
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      bit found;
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      lat   = 1;
      exp_pc = RST_PC;
      fif.imem_req_ready  = 1'b0;
      fif.imem_resp_valid = 1'b0;
      fif.imem_resp_data  = NOP_INSTR;
      fif.instr_ready     = 1'b0;

      // Reset values
      @(negedge clk);
      #1 reset_checks("rst");
      @(negedge clk);
      rst_n = 1'b1;
      boot  = 1'b1;

      // BOOT cycle, first request at RESET_PC, then memory stalls with address held
      step(1'b1, 1'b1, 0, 32'd0);
      step(1'b1, 1'b1, 0, 32'd0);
      chk("first_req", at(req_log, 0), RST_PC);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 0, 32'd0);
         #1;
         chk("hold_addr", fif.imem_req_addr, 32'h0000_0104);
         chk("hold_valid", 32'(fif.imem_req_valid), 32'd1);
      end

      // Streaming with L=1 and an always-ready decoder
      for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 0, 32'd0);

      // Decoder stall: credit runs out, then drains without loss
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 32'd0);
      #1 chk("credit_stall", 32'(fif.imem_req_valid), 32'd0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 0, 32'd0);

      // L=3, two requests in flight, redirect to an unaligned target
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if ((mem_q.size() == 2) && (stale_cnt() == 0)) found = 1'b1;
         else step(1'b1, 1'b1, 0, 32'd0);
      end
      chk("l3_setup", 32'(found), 32'd1);
      req_log.delete();
      pc_log.delete();
      step(1'b1, 1'b1, 1, 32'h0000_2002);
      for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 0, 32'd0);
      chk("redir_req", at(req_log, 0), 32'h0000_2000);
      chk("redir_pc", at(pc_log, 0), 32'h0000_2000);

      // Redirect coinciding with a response and a request handshake
      lat = 1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1'b1, 1'b1, 2, 32'h0000_3000);
         found = did_redir;
      end
      chk("coincide_setup", 32'(found), 32'd1);
      req_log.delete();
      pc_log.delete();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 0, 32'd0);
      chk("coincide_req", at(req_log, 0), 32'h0000_3000);
      chk("coincide_pc", at(pc_log, 0), 32'h0000_3000);

      // PC wraps modulo 2^32
      step(1'b1, 1'b1, 1, 32'hFFFF_FFF9);
      req_log.delete();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 0, 32'd0);
      chk("wrap_0", at(req_log, 0), 32'hFFFF_FFF8);
      chk("wrap_1", at(req_log, 1), 32'hFFFF_FFFC);
      chk("wrap_2", at(req_log, 2), 32'h0000_0000);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] rpc;
         int          mode;
         if ((mem_q.size() == 0) && ($urandom_range(0, 15) == 0)) lat = $urandom_range(1, 3);
         mode = ((stale_cnt() == 0) && ($urandom_range(0, 19) == 0)) ? 1 : 0;
         rpc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, mode, rpc);
      end

      // Asynchronous reset mid-operation
      #2 rst_n = 1'b0;
      #1 reset_checks("async_rst");
      mem_q.delete();
      dq.delete();
      fif.imem_resp_valid = 1'b0;
      exp_pc = RST_PC;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      boot  = 1'b1;
      req_log.delete();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 0, 32'd0);
      chk("restart_req", at(req_log, 0), RST_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
